reservoir_ring: RTL and testbench

- Parametrised integer echo-state reservoir with N neurons on a ring (simple-cycle) topology.
- Per step it folds the input word and the feedback value into all neuron states, with optional leaky integration.
- Updates are time-multiplexed: one neuron per clock.
- Sits between the input word encoder and the linear readout; exposes both a selected state and the full state vector.

---
 rtl/reservoir_ring_if.sv | 31 +++
 rtl/reservoir_ring.sv | 151 +++++++++++++++
 tb/tb_reservoir_ring.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/reservoir_ring_if.sv
// Handshake and state-bus bundle for the ring reservoir.
// The master side issues step/clear requests and picks a neuron to view.
// The slave side returns neuron states together with step status.
interface reservoir_ring_if #(
  parameter int N  = 8,
  parameter int SW = 9,
  parameter int WW = 3,
  parameter int YW = 6
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  logic                   iEn;
  logic                   iClear;
  logic [WW-1:0]          iWord;
  logic signed [YW-1:0]   iY;
  logic [KW-1:0]          iSel;
  logic signed [SW-1:0]   oOut;
  logic [N*SW-1:0]        oStates;
  logic                   oValid;
  logic                   oBusy;

  modport master (
    output iEn, iClear, iWord, iY, iSel,
    input  oOut, oStates, oValid, oBusy
  );

  modport slave (
    input  iEn, iClear, iWord, iY, iSel,
    output oOut, oStates, oValid, oBusy
  );
endinterface

// File: rtl/reservoir_ring.sv
// Integer echo-state reservoir with N neurons on a ring.
// A step updates one neuron per clock, from k=N-1 down to k=0. Because each
// update reads only its lower neighbour, and that neighbour has not been
// updated yet, the result matches a simultaneous update. The single exception
// is neuron 0: its neighbour x[N-1] is overwritten first, so the old value is
// saved at accept time.
//
// state | meaning
// IDLE  | waiting; iClear zeroes all states, iEn captures u/y and starts a step
// BUSY  | updates neuron k each cycle, k counts N-1 -> 0
// DONE  | oValid pulse for one cycle, then back to IDLE
module reservoir_ring #(
  parameter int          N       = 8,
  parameter int          SW      = 9,
  parameter int          WW      = 3,
  parameter int          YW      = 6,
  parameter int          R       = 3,
  parameter int          RSH     = 2,
  parameter int          V       = 8,
  parameter int          F       = 2,
  parameter logic [N-1:0] IN_SIGN = 8'b10110101,
  parameter logic [N-1:0] FB_SIGN = 8'b01011010,
  parameter int          LEAK_SH = 0
) (
  input logic           iClk,
  input logic           iRst,
  reservoir_ring_if.slave bus
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  // Wide enough that the ring product plus both input terms cannot overflow.
  localparam int PW = SW + WW + YW + 16;

  localparam logic signed [PW-1:0] R_W    = PW'(R);
  localparam logic signed [PW-1:0] V_W    = PW'(V);
  localparam logic signed [PW-1:0] F_W    = PW'(F);
  localparam logic signed [PW-1:0] SMAX_W = (PW'(1) <<< (SW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SMIN_W = -(PW'(1) <<< (SW - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic signed [SW-1:0] x_q [N];
  logic [KW-1:0]        k_q;
  logic [WW-1:0]        u_q;
  logic signed [YW-1:0] y_q;
  logic signed [SW-1:0] tmp_q;
  logic                 valid_q;
  logic                 busy_q;

  logic signed [SW-1:0] x_new_d;
  logic signed [SW-1:0] prev_s;
  logic signed [SW-1:0] old_s;
  logic signed [PW-1:0] prev_w;
  logic signed [PW-1:0] old_w;
  logic signed [PW-1:0] u_w;
  logic signed [PW-1:0] y_w;
  logic signed [PW-1:0] ring_w;
  logic signed [PW-1:0] in_w;
  logic signed [PW-1:0] fb_w;
  logic signed [PW-1:0] pre_w;
  logic signed [PW-1:0] acc_w;

  // Next value for neuron k, computed at full precision and then saturated.
  always_comb begin
    prev_s  = (k_q == '0) ? tmp_q : x_q[k_q - KW'(1)];
    old_s   = x_q[k_q];
    prev_w  = {{(PW - SW){prev_s[SW-1]}}, prev_s};
    old_w   = {{(PW - SW){old_s[SW-1]}}, old_s};
    u_w     = {{(PW - WW){1'b0}}, u_q};
    y_w     = {{(PW - YW){y_q[YW-1]}}, y_q};
    ring_w  = (prev_w * R_W) >>> RSH;
    in_w    = IN_SIGN[k_q] ? (V_W * u_w) : -(V_W * u_w);
    fb_w    = FB_SIGN[k_q] ? (F_W * y_w) : -(F_W * y_w);
    pre_w   = ring_w + in_w + fb_w;
    if (LEAK_SH == 0) begin
      acc_w = pre_w;
    end else begin
      acc_w = old_w - (old_w >>> LEAK_SH) + (pre_w >>> LEAK_SH);
    end
    if (acc_w > SMAX_W) begin
      x_new_d = SMAX_W[SW-1:0];
    end else if (acc_w < SMIN_W) begin
      x_new_d = SMIN_W[SW-1:0];
    end else begin
      x_new_d = acc_w[SW-1:0];
    end
  end

  // Step sequencer: owns the neuron states, index, captured inputs and status flags.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
      k_q     <= '0;
      u_q     <= '0;
      y_q     <= '0;
      tmp_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (bus.iClear) begin
            for (int i = 0; i < N; i++) x_q[i] <= '0;
          end else if (bus.iEn) begin
            u_q     <= bus.iWord;
            y_q     <= bus.iY;
            tmp_q   <= x_q[N-1];
            k_q     <= KW'(N - 1);
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          x_q[k_q] <= x_new_d;
          if (k_q == '0) begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q <= k_q - KW'(1);
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output views of the registered states.
  always_comb begin
    bus.oStates = '0;
    for (int i = 0; i < N; i++) bus.oStates[i*SW +: SW] = x_q[i];
    bus.oOut = '0;
    if (int'(bus.iSel) < N) bus.oOut = x_q[bus.iSel];
    bus.oValid = valid_q;
    bus.oBusy  = busy_q;
  end
endmodule

// File: tb/tb_reservoir_ring.sv
// Directed bench for reservoir_ring. Three builds run the same stimulus in
// lockstep: the default build (m), a leaky build (l, LEAK_SH=1) and a
// high-gain build (s, RSH=0). The high-gain build drives states into saturation.
module tb_reservoir_ring;
  localparam int N = 8;
  localparam int SW = 9;
  localparam int WW = 3;
  localparam int YW = 6;
  localparam int KW = 3;
  localparam logic [7:0] IN_S = 8'b10110101;
  localparam logic [7:0] FB_S = 8'b01011010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [WW-1:0] word = '0;
  logic [YW-1:0] yv = '0;
  logic [KW-1:0] sel = 3'd3;

  int tests = 0;
  int fails = 0;
  int mx [N];

  always #5 clk = ~clk;

  reservoir_ring_if #(.N(N), .SW(SW), .WW(WW), .YW(YW)) ifm ();
  reservoir_ring_if #(.N(N), .SW(SW), .WW(WW), .YW(YW)) ifl ();
  reservoir_ring_if #(.N(N), .SW(SW), .WW(WW), .YW(YW)) ifs ();

  assign ifm.iEn = en;  assign ifm.iClear = clr; assign ifm.iWord = word;
  assign ifm.iY = yv;   assign ifm.iSel = sel;
  assign ifl.iEn = en;  assign ifl.iClear = clr; assign ifl.iWord = word;
  assign ifl.iY = yv;   assign ifl.iSel = sel;
  assign ifs.iEn = en;  assign ifs.iClear = clr; assign ifs.iWord = word;
  assign ifs.iY = yv;   assign ifs.iSel = sel;

  reservoir_ring #(.N(N), .SW(SW), .WW(WW), .YW(YW)) dut_m (
    .iClk(clk), .iRst(rst), .bus(ifm));
  reservoir_ring #(.N(N), .SW(SW), .WW(WW), .YW(YW), .LEAK_SH(1)) dut_l (
    .iClk(clk), .iRst(rst), .bus(ifl));
  reservoir_ring #(.N(N), .SW(SW), .WW(WW), .YW(YW), .RSH(0)) dut_s (
    .iClk(clk), .iRst(rst), .bus(ifs));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] st(input int which, input int i);
    logic signed [SW-1:0] v;
    case (which)
      0:       v = ifm.oStates[i*SW +: SW];
      1:       v = ifl.oStates[i*SW +: SW];
      default: v = ifs.oStates[i*SW +: SW];
    endcase
    return 32'(v);
  endfunction

  task automatic chk_vec(input string tag, input int which, input int e [N]);
    for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), st(which, i), e[i]);
  endtask

  function automatic int sat(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  // Reference for the default build: simultaneous update from old states.
  task automatic model_step(input int u, input int y);
    int nx [N];
    int prev, pre, si, sf;
    for (int i = 0; i < N; i++) begin
      prev = mx[(i + N - 1) % N];
      si = IN_S[i] ? 1 : -1;
      sf = FB_S[i] ? 1 : -1;
      pre = ((prev * 3) >>> 2) + si * 8 * u + sf * 2 * y;
      nx[i] = sat(pre);
    end
    mx = nx;
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) mx[i] = 0;
  endtask

  // One full step with timing checks; cycle 1 is the cycle after the accept edge.
  task automatic do_step(input string tag, input int u, input int y);
    int busy_cnt, valid_cnt, valid_cyc, idle_ok;
    @(negedge clk);
    en = 1'b1; word = u[WW-1:0]; yv = y[YW-1:0];
    @(posedge clk); #1;
    en = 1'b0;
    busy_cnt = 0; valid_cnt = 0; valid_cyc = -1; idle_ok = 0;
    for (int c = 1; c <= N + 4; c++) begin
      if (ifm.oBusy === 1'b1) busy_cnt++;
      if (ifm.oValid === 1'b1) begin valid_cnt++; valid_cyc = c; end
      if (c == N + 2 && ifm.oBusy === 1'b0 && ifm.oValid === 1'b0) idle_ok = 1;
      @(posedge clk); #1;
    end
    chk({tag, ".busy_cycles"}, busy_cnt, N + 1);
    chk({tag, ".valid_count"}, valid_cnt, 1);
    chk({tag, ".valid_cycle"}, valid_cyc, N + 1);
    chk({tag, ".idle_after"}, idle_ok, 1);
    model_step(u, y);
  endtask

  initial begin : main
    int z    [N] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int e1   [N] = '{56, -56, 56, -56, 56, 56, -56, 56};
    int e2   [N] = '{42, 42, -42, 42, -42, 42, 42, -42};
    int l1   [N] = '{28, -28, 28, -28, 28, 28, -28, 28};
    int s2   [N] = '{168, 168, -168, 168, -168, 168, 168, -168};
    int s3   [N] = '{-256, 255, 255, -256, 255, -256, 255, 255};
    int s4   [N] = '{255, -256, 255, 255, -256, 255, -256, 255};
    int in_range, vcnt, pinned;

    model_zero();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("reset.busy", 32'(ifm.oBusy), 0);
    chk("reset.valid", 32'(ifm.oValid), 0);
    chk_vec("reset.m", 0, z);

    do_step("zero_step", 0, 0);
    chk_vec("zero_step.m", 0, z);

    do_step("u7", 7, 0);
    chk_vec("u7.m", 0, e1);
    chk("u7.oOut_sel3", 32'(ifm.oOut), -56);
    chk_vec("u7.leak", 1, l1);
    chk_vec("u7.gain", 2, e1);

    do_step("decay", 0, 0);
    chk_vec("decay.m", 0, e2);
    chk_vec("decay.gain", 2, s2);

    do_step("sat1", 0, 0);
    chk_vec("sat1.gain", 2, s3);
    do_step("sat2", 0, 0);
    chk_vec("sat2.gain", 2, s4);
    for (int i = 0; i < N; i++) chk($sformatf("sat2.model_m[%0d]", i), st(0, i), mx[i]);

    // Clear and step request together: clear wins, no step starts.
    @(negedge clk); clr = 1'b1; en = 1'b1; word = 3'd7;
    @(posedge clk); #1;
    clr = 1'b0; en = 1'b0;
    chk("clear.busy", 32'(ifm.oBusy), 0);
    chk_vec("clear.m", 0, z);
    chk_vec("clear.leak", 1, z);
    chk_vec("clear.gain", 2, z);
    @(posedge clk); #1;
    chk("clear.busy_next", 32'(ifl.oBusy), 0);
    chk("clear.valid_next", 32'(ifl.oValid), 0);
    model_zero();

    // Twelve driven steps against the reference.
    in_range = 1;
    pinned = 0;
    for (int s = 0; s < 12; s++) begin
      do_step($sformatf("drive%0d", s), 7, 31);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("drive%0d.m[%0d]", s, i), st(0, i), mx[i]);
        if (st(0, i) > 255 || st(0, i) < -256) in_range = 0;
        if (st(2, i) == 255 || st(2, i) == -256) pinned = 1;
      end
    end
    chk("drive.in_range", in_range, 1);
    chk("drive.gain_pinned", pinned, 1);

    // Step request during BUSY is ignored, and the inputs are not resampled.
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; en = 1'b1; word = 3'd7; yv = '0;
    @(posedge clk); #1;
    en = 1'b0;
    vcnt = 0;
    for (int c = 1; c <= 2 * N + 6; c++) begin
      if (c == 3) begin en = 1'b1; word = 3'd3; yv = 6'd5; end
      if (c == 4) begin en = 1'b0; word = 3'd0; yv = '0; end
      if (ifm.oValid === 1'b1) vcnt++;
      @(posedge clk); #1;
    end
    chk("busy_en.valid_count", vcnt, 1);
    chk_vec("busy_en.m", 0, e1);

    // Reset in BUSY cycle 4 abandons the step; a new request is taken at once.
    @(negedge clk); en = 1'b1; word = 3'd7; yv = '0;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst.busy", 32'(ifm.oBusy), 0);
    chk("mid_rst.valid", 32'(ifm.oValid), 0);
    chk_vec("mid_rst.m", 0, z);
    chk_vec("mid_rst.leak", 1, z);
    en = 1'b1; word = 3'd7; yv = '0;
    @(posedge clk); #1;
    en = 1'b0;
    chk("mid_rst.reaccept_busy", 32'(ifm.oBusy), 1);
    vcnt = 0;
    for (int c = 1; c <= N + 4; c++) begin
      if (ifm.oValid === 1'b1) vcnt++;
      @(posedge clk); #1;
    end
    chk("mid_rst.valid_count", vcnt, 1);
    chk_vec("mid_rst.after", 0, e1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
